// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
//
// Contents:
//   state_t     : arbiter FSM states
//   requester_t : port owner (fetch refill I, load/store D)
//   SIZE_*      : SizeSrc encodings forwarded to the memory
//   mem_req_t   : latched access fields
//   other_req   : the opposite requester, used for round-robin ties
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [1:0]            size;
        logic                  sign;
    } mem_req_t;

    function automatic requester_t other_req(input requester_t r);
        return (r == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, purely combinational
//
// Ports:
//   i_req[1:0]   : request vector, bit 0 = I, bit 1 = D
//   i_last_grant : requester served most recently
//   o_valid      : at least one request present
//   o_grant      : requester to serve next
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  requester_t i_last_grant,
    output logic       o_valid,
    output requester_t o_grant
);

    always_comb begin
        o_valid = |i_req;
        o_grant = REQ_I;
        if (i_req == 2'b11) begin
            // Tie: whoever did not go last wins, so neither side starves.
            o_grant = other_req(i_last_grant);
        end else if (i_req[1]) begin
            o_grant = REQ_D;
        end else begin
            o_grant = REQ_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory between fetch and load/store
//
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   i_req, i_addr             : fetch refill request (always a word read)
//   d_req, d_we, d_addr,
//   d_wdata, d_size, d_sign   : MEM-stage load/store request
//   i_done, d_done            : one-cycle completion pulse per requester
//   rdata                     : registered read data, held outside DONE
//   i_stall, d_stall          : request pending and not completing this cycle
//   mem_*                     : memory interface; mem_rdata returns read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_sign,
    output logic              i_done,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              i_stall,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be within 1..15");
    end
    if (ADDR_W > ARB_ADDR_W || DATA_W > ARB_DATA_W) begin : g_bad_width
        $error("mem_port_arbiter: ADDR_W/DATA_W exceed package field widths");
    end

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t            r_state;
    state_t            w_next_state;
    requester_t        r_owner;
    requester_t        r_last_grant;
    logic [3:0]        r_cnt;
    mem_req_t          r_req;
    logic [DATA_W-1:0] r_rdata;

    logic              w_gnt_valid;
    requester_t        w_gnt;
    mem_req_t          w_i_fields;
    mem_req_t          w_d_fields;

    rr_arb2 u_rr_arb2 (
        .i_req        ({d_req, i_req}),
        .i_last_grant (r_last_grant),
        .o_valid      (w_gnt_valid),
        .o_grant      (w_gnt)
    );

    // Fields each requester would latch on grant; fetch is a plain word read.
    always_comb begin
        w_i_fields       = '0;
        w_i_fields.we    = 1'b0;
        w_i_fields.addr  = ARB_ADDR_W'(i_addr);
        w_i_fields.size  = SIZE_WORD;
        w_i_fields.sign  = 1'b0;

        w_d_fields       = '0;
        w_d_fields.we    = d_we;
        w_d_fields.addr  = ARB_ADDR_W'(d_addr);
        w_d_fields.wdata = ARB_DATA_W'(d_wdata);
        w_d_fields.size  = d_size;
        w_d_fields.sign  = d_sign;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_owner      <= REQ_I;
            r_last_grant <= REQ_I;
            r_cnt        <= '0;
            r_req        <= '0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner <= w_gnt;
                        r_cnt   <= CNT_INIT;
                        r_req   <= (w_gnt == REQ_D) ? w_d_fields : w_i_fields;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rdata <= mem_rdata;
                    end
                end
                DONE: begin
                    r_last_grant <= r_owner;
                end
                default: ;
            endcase
        end
    end

    // Next state. DONE never samples requests: the owner's req is still
    // high there and would otherwise be granted a second time.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid) w_next_state = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs. Only mem_en and mem_we are gated; the other memory fields
    // always show the latched request.
    always_comb begin
        mem_en    = (r_state == BUSY);
        mem_we    = (r_state == BUSY) & r_req.we;
        mem_addr  = r_req.addr[ADDR_W-1:0];
        mem_wdata = r_req.wdata[DATA_W-1:0];
        mem_size  = r_req.size;
        mem_sign  = r_req.sign;
        i_done    = (r_state == DONE) && (r_owner == REQ_I);
        d_done    = (r_state == DONE) && (r_owner == REQ_D);
        rdata     = r_rdata;
        i_stall   = i_req & ~i_done;
        d_stall   = d_req & ~d_done;
    end

    a_i_req_held: assert property (@(posedge clk) disable iff (!rst)
        (r_state == BUSY && r_owner == REQ_I) |-> i_req);
    a_d_req_held: assert property (@(posedge clk) disable iff (!rst)
        (r_state == BUSY && r_owner == REQ_D) |-> d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 2;

    typedef struct {
        logic        who;    // 1 = D, 0 = I
        logic        we;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          done_k;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_req, d_req, d_we, d_sign;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        i_done, d_done, i_stall, d_stall, mem_en, mem_we, mem_sign;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;

    logic        i_req1, d_req1, d_we1, d_sign1;
    logic [31:0] i_addr1, d_addr1, d_wdata1;
    logic [1:0]  d_size1;
    logic        i_done1, d_done1, i_stall1, d_stall1, mem_en1, mem_we1, mem_sign1;
    logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [1:0]  mem_size1;

    int   n_pass;
    int   n_total;
    exp_t sb[$];

    mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_sign(d_sign),
        .i_done(i_done), .d_done(d_done), .rdata(rdata),
        .i_stall(i_stall), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_size(d_size1), .d_sign(d_sign1),
        .i_done(i_done1), .d_done(d_done1), .rdata(rdata1),
        .i_stall(i_stall1), .d_stall(d_stall1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_size(mem_size1), .mem_sign(mem_sign1),
        .mem_rdata(mem_rdata1)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return a * 32'd3 + 32'h1111_0000;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb mem_rdata  = mem_en  ? mem_fn(mem_addr)  : 32'h0;
    always_comb mem_rdata1 = mem_en1 ? mem_fn(mem_addr1) : 32'h0;

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b expected 0", mem_en); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we); else n_pass++;
        n_total++; if ({i_done, d_done} !== 2'b00) $display("FAIL reset_done: got %b expected 00", {i_done, d_done}); else n_pass++;
        n_total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else n_pass++;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); else n_pass++;
        n_total++; if ({mem_size, mem_sign} !== 3'b000) $display("FAIL reset_size_sign: got %b expected 000", {mem_size, mem_sign}); else n_pass++;
        n_total++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata_lat1: got %h expected 0", rdata1); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_load();
        exp_t e;
        exp_t g;
        e.who = 1'b1; e.we = 1'b0; e.addr = 32'h100; e.rdata = mem_fn(32'h100); e.done_k = LAT + 1;
        sb.push_back(e);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0; d_size = SIZE_WORD; d_sign = 1'b0;
        #1;
        n_total++; if (d_stall !== 1'b1) $display("FAIL load_stall_t: got %b expected 1", d_stall); else n_pass++;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k <= LAT) begin
                n_total++; if (mem_en !== 1'b1) $display("FAIL load_mem_en k=%0d: got %b expected 1", k, mem_en); else n_pass++;
                n_total++; if (mem_addr !== 32'h100) $display("FAIL load_mem_addr k=%0d: got %h expected 100", k, mem_addr); else n_pass++;
                n_total++; if (d_stall !== 1'b1) $display("FAIL load_stall k=%0d: got %b expected 1", k, d_stall); else n_pass++;
            end else begin
                n_total++; if (d_done !== 1'b1) $display("FAIL load_done: got %b expected 1", d_done); else n_pass++;
                n_total++; if (d_stall !== 1'b0) $display("FAIL load_stall_done: got %b expected 0", d_stall); else n_pass++;
                n_total++; if (mem_en !== 1'b0) $display("FAIL load_mem_en_done: got %b expected 0", mem_en); else n_pass++;
                if (d_done === 1'b1 && sb.size() > 0) begin
                    g = sb.pop_front();
                    n_total++; if (rdata !== g.rdata) $display("FAIL load_rdata: got %h expected %h", rdata, g.rdata); else n_pass++;
                end
            end
        end
        d_req = 1'b0;
        n_total++; if (sb.size() != 0) $display("FAIL load_sb_empty: got %0d entries expected 0", sb.size()); else n_pass++;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int spurious;
        spurious = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_size = SIZE_WORD; d_sign = 1'b0;
        @(negedge clk);
        n_total++; if (mem_en !== 1'b1) $display("FAIL rstbusy_mem_en_before: got %b expected 1", mem_en); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (mem_en !== 1'b0) $display("FAIL rstbusy_mem_en_after: got %b expected 0", mem_en); else n_pass++;
        n_total++; if (rdata !== 32'h0) $display("FAIL rstbusy_rdata: got %h expected 0", rdata); else n_pass++;
        rst = 1'b1;
        d_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (d_done === 1'b1 || i_done === 1'b1 || mem_en === 1'b1) spurious++;
        end
        n_total++; if (spurious != 0) $display("FAIL rstbusy_no_activity: got %0d active cycles expected 0", spurious); else n_pass++;
    endtask

    task automatic test_simultaneous();
        exp_t e;
        exp_t g;
        e.who = 1'b1; e.we = 1'b1; e.addr = 32'h300; e.rdata = 32'h0; e.done_k = LAT + 1;
        sb.push_back(e);
        e.who = 1'b0; e.we = 1'b0; e.addr = 32'h200; e.rdata = mem_fn(32'h200); e.done_k = 2 * LAT + 3;
        sb.push_back(e);
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFE_0001; d_size = SIZE_BYTE; d_sign = 1'b1;
        for (int k = 1; k <= 12 && sb.size() > 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_total++; if (mem_addr !== 32'h300) $display("FAIL simul_first_addr: got %h expected 300", mem_addr); else n_pass++;
                n_total++; if (mem_sign !== 1'b1) $display("FAIL simul_first_sign: got %b expected 1", mem_sign); else n_pass++;
            end
            if (k == LAT + 3) begin
                n_total++; if ({mem_en, mem_we} !== 2'b10) $display("FAIL simul_i_en_we: got %b expected 10", {mem_en, mem_we}); else n_pass++;
                n_total++; if (mem_size !== SIZE_WORD) $display("FAIL simul_i_size: got %b expected 00", mem_size); else n_pass++;
                n_total++; if (mem_sign !== 1'b0) $display("FAIL simul_i_sign: got %b expected 0", mem_sign); else n_pass++;
                n_total++; if (mem_addr !== 32'h200) $display("FAIL simul_i_addr: got %h expected 200", mem_addr); else n_pass++;
            end
            if (i_done === 1'b1 || d_done === 1'b1) begin
                g = sb.pop_front();
                n_total++; if (d_done !== g.who) $display("FAIL simul_owner k=%0d: got d_done=%b expected %b", k, d_done, g.who); else n_pass++;
                n_total++; if (k != g.done_k) $display("FAIL simul_done_cycle: got %0d expected %0d", k, g.done_k); else n_pass++;
                if (!g.we) begin
                    n_total++; if (rdata !== g.rdata) $display("FAIL simul_rdata: got %h expected %h", rdata, g.rdata); else n_pass++;
                end
                if (d_done === 1'b1) d_req = 1'b0;
                if (i_done === 1'b1) i_req = 1'b0;
            end
        end
        n_total++; if (sb.size() != 0) $display("FAIL simul_sb_empty: got %0d entries expected 0", sb.size()); else n_pass++;
        sb.delete();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_sign = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t g;
        int   run;
        int   n_d;
        int   n_i;
        run = 0; n_d = 0; n_i = 0;
        for (int n = 0; n < 4; n++) begin
            e.who = (n % 2 == 0);
            e.we = 1'b0;
            e.addr = e.who ? (32'h1000 + 32'(4 * (n / 2))) : (32'h2000 + 32'(4 * (n / 2)));
            e.rdata = mem_fn(e.addr);
            e.done_k = (LAT + 2) * n + LAT + 1;
            sb.push_back(e);
        end
        d_we = 1'b0; d_size = SIZE_WORD; d_sign = 1'b0;
        d_addr = 32'h1000; i_addr = 32'h2000;
        d_req = 1'b1; i_req = 1'b1;
        for (int k = 1; k <= 40 && sb.size() > 0; k++) begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                run++;
                n_total++; if (mem_addr !== sb[0].addr) $display("FAIL b2b_addr k=%0d: got %h expected %h", k, mem_addr, sb[0].addr); else n_pass++;
            end else if (run > 0) begin
                n_total++; if (run != LAT) $display("FAIL b2b_en_len: got %0d expected %0d", run, LAT); else n_pass++;
                run = 0;
            end
            if (i_done === 1'b1 || d_done === 1'b1) begin
                n_total++; if ((i_done & d_done) !== 1'b0) $display("FAIL b2b_double_done k=%0d: got both expected one", k); else n_pass++;
                g = sb.pop_front();
                n_total++; if (d_done !== g.who) $display("FAIL b2b_order k=%0d: got d_done=%b expected %b", k, d_done, g.who); else n_pass++;
                n_total++; if (k != g.done_k) $display("FAIL b2b_done_cycle: got %0d expected %0d", k, g.done_k); else n_pass++;
                n_total++; if (rdata !== g.rdata) $display("FAIL b2b_rdata k=%0d: got %h expected %h", k, rdata, g.rdata); else n_pass++;
                if (d_done === 1'b1) begin
                    n_d++;
                    d_addr = 32'h1000 + 32'(4 * n_d);
                    if (n_d == 2) d_req = 1'b0;
                end
                if (i_done === 1'b1) begin
                    n_i++;
                    i_addr = 32'h2000 + 32'(4 * n_i);
                    if (n_i == 2) i_req = 1'b0;
                end
            end
        end
        n_total++; if (sb.size() != 0) $display("FAIL b2b_sb_empty: got %0d entries expected 0", sb.size()); else n_pass++;
        sb.delete();
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        exp_t e;
        exp_t g;
        int   idone_seen;
        idone_seen = 0;
        e.who = 1'b1; e.we = 1'b1; e.addr = 32'h20; e.rdata = 32'h0; e.done_k = LAT + 1;
        sb.push_back(e);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_size = SIZE_BYTE; d_sign = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (i_done === 1'b1) idone_seen++;
            if (k <= LAT) begin
                n_total++; if ({mem_en, mem_we} !== 2'b11) $display("FAIL store_en_we k=%0d: got %b expected 11", k, {mem_en, mem_we}); else n_pass++;
                n_total++; if (mem_size !== SIZE_BYTE) $display("FAIL store_size k=%0d: got %b expected 10", k, mem_size); else n_pass++;
                n_total++; if (mem_wdata !== 32'h12345678) $display("FAIL store_wdata k=%0d: got %h expected 12345678", k, mem_wdata); else n_pass++;
                n_total++; if (mem_addr !== 32'h20) $display("FAIL store_addr k=%0d: got %h expected 20", k, mem_addr); else n_pass++;
            end else begin
                n_total++; if (mem_we !== 1'b0) $display("FAIL store_we_done: got %b expected 0", mem_we); else n_pass++;
                if (d_done === 1'b1 && sb.size() > 0) begin
                    g = sb.pop_front();
                    n_total++; if (k != g.done_k) $display("FAIL store_done_cycle: got %0d expected %0d", k, g.done_k); else n_pass++;
                end
            end
        end
        d_req = 1'b0; d_we = 1'b0;
        n_total++; if (idone_seen != 0) $display("FAIL store_i_done: got %0d pulses expected 0", idone_seen); else n_pass++;
        n_total++; if (sb.size() != 0) $display("FAIL store_sb_empty: got %0d entries expected 0", sb.size()); else n_pass++;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_latency1();
        exp_t e;
        exp_t g;
        e.who = 1'b0; e.we = 1'b0; e.addr = 32'h0; e.rdata = mem_fn(32'h0); e.done_k = 2;
        sb.push_back(e);
        i_req1 = 1'b1; i_addr1 = 32'h0;
        @(negedge clk);
        n_total++; if (mem_en1 !== 1'b1) $display("FAIL lat1_mem_en: got %b expected 1", mem_en1); else n_pass++;
        n_total++; if (mem_addr1 !== 32'h0) $display("FAIL lat1_addr: got %h expected 0", mem_addr1); else n_pass++;
        n_total++; if (i_done1 !== 1'b0) $display("FAIL lat1_early_done: got %b expected 0", i_done1); else n_pass++;
        @(negedge clk);
        n_total++; if (i_done1 !== 1'b1) $display("FAIL lat1_done: got %b expected 1", i_done1); else n_pass++;
        n_total++; if (mem_en1 !== 1'b0) $display("FAIL lat1_mem_en_done: got %b expected 0", mem_en1); else n_pass++;
        if (i_done1 === 1'b1 && sb.size() > 0) begin
            g = sb.pop_front();
            n_total++; if (rdata1 !== g.rdata) $display("FAIL lat1_rdata: got %h expected %h", rdata1, g.rdata); else n_pass++;
        end
        i_req1 = 1'b0;
        n_total++; if (sb.size() != 0) $display("FAIL lat1_sb_empty: got %0d entries expected 0", sb.size()); else n_pass++;
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_size = SIZE_WORD; d_sign = 1'b0;
        i_req1 = 1'b0; i_addr1 = 32'h0;
        d_req1 = 1'b0; d_we1 = 1'b0; d_addr1 = 32'h0; d_wdata1 = 32'h0; d_size1 = SIZE_WORD; d_sign1 = 1'b0;

        test_reset();
        test_single_load();
        test_reset_mid_busy();
        test_simultaneous();
        test_back_to_back();
        test_store();
        test_latency1();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
